pipe_stage_reg: RTL
===================

Name: pipe_stage_reg

Overview:
Parametrised pipeline-stage register, the generalised successor of the fixed-field inter-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries a control bundle and a data bundle between stages with a valid/ready handshake and optional skid buffering. It also supports hazard stall, flush with bubble insertion (control zeroed) and a saturating counter of flushed entries. One instance sits between each pair of pipeline stages.

Parameters:
CTRL_W, 8, width of control bundle (zeroed on reset and flush)
DATA_W, 64, width of data bundle (retained on flush)
SKID, 1, 1 = two-entry skid buffer with registered ready_o; 0 = single entry with combinational ready_o
CNT_W, 8, width of drop counter

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous active-low reset
start_i  in  1  global run enable; low = freeze all state
stall_i  in  1  hazard hold from hazard unit
flush_i  in  1  synchronous flush / bubble insert
valid_i  in  1  upstream entry valid
ready_o  out  1  stage can accept
ctrl_i  in  CTRL_W  upstream control bundle
data_i  in  DATA_W  upstream data bundle
valid_o  out  1  downstream entry valid
ready_i  in  1  downstream can accept
ctrl_o  out  CTRL_W  control bundle; 0 whenever valid_o=0 after reset or flush
data_o  out  DATA_W  data bundle
drop_cnt_o  out  CNT_W  saturating count of valid entries discarded by flush

Behaviour:
- Reset (rst_i low, async): main and skid valid=0; ctrl=0; data=0; drop_cnt_o=0. Outputs reflect this immediately.
- Accept = valid_i & ready_o. Emit = valid_o & ready_i & ~stall_i & start_i.
- Priority per cycle: start_i=0 > flush_i > stall_i > normal.
- start_i=0: no state changes; ready_o=0; no emit (valid_o still shows the held entry).
- flush_i=1 (start_i=1): main and skid valid cleared; ctrl regs cleared to 0; data regs unchanged. Same-cycle input is not accepted (ready_o=0). drop_cnt += (main valid)+(skid valid), saturating at 2^CNT_W-1. Flush overrides stall and emit.
- stall_i=1: ready_o=0; all regs hold; downstream ready_i ignored (no emit); valid_o keeps its value.
- SKID=0: ready_o = start_i & ~flush_i & ~stall_i & (~valid_o | ready_i).
  - Accept loads main next edge.
  - Emit without accept clears main valid and ctrl.
  - Accept and emit together replace main. Latency valid_i to valid_o: 1 cycle.
- SKID=1: ready_o = start_i & ~flush_i & ~stall_i & ~skid_valid. Register portion has no combinational path from ready_i.
  - Outputs always come from main.
  - Accept while main empty, or main emitting: write main.
  - Accept while main full and not emitting: write skid.
  - Emit with skid full: main <= skid; skid cleared (valid, ctrl=0).
  - Emit with skid empty and no accept: main cleared.
  - Skid never written while skid full; accept is impossible in that state.
  - Throughput 1/cycle when ready_i held high. Latency 1 cycle.
- Ordering strictly FIFO; no entry duplicated or lost except by flush.
- Counter saturates and holds at max; only reset clears it.
- ctrl_i/data_i are X-tolerant when valid_i=0: not captured.

Test Plan:
- Reset mid-stream: main valid, ctrl=8'hA5, drop_cnt=3; assert rst_i low between edges -> valid_o=0, ctrl_o=0, data_o=0, drop_cnt_o=0 immediately; after release, first accept appears 1 cycle later.
- Streaming, SKID=1, ready_i=1, 10 entries data=1..10 back-to-back -> valid_o high cycles 1..10, data_o 1..10 in order, ready_o constantly 1.
- Backpressure, SKID=1: ready_i=0 after entry 1 accepted, valid_i stays high with 2,3 -> entry 2 goes to skid, ready_o=0 next cycle, entry 3 held upstream; ready_i=1 -> outputs 1,2,3 consecutive, none lost.
- Flush with both entries full (ctrl=8'h3C, data=64'hDEAD) plus valid_i=1 same cycle -> next cycle valid_o=0, ctrl_o=0, data_o=64'hDEAD, drop_cnt_o +2, input not accepted.
- Stall vs flush: stall_i=1 for 3 cycles holding entry ctrl=8'h11 -> valid_o/ctrl_o stable, ready_o=0, no emit despite ready_i=1; then stall_i=1 and flush_i=1 together -> flush wins, drop_cnt_o +1.
- SKID=0 with CNT_W=2: 5 flushes of a valid entry -> drop_cnt_o 1,2,3,3,3. start_i=0 for 2 cycles -> state frozen, ready_o=0.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg
//
// Generic inter-stage pipeline register. It carries a control bundle and a
// data bundle from one pipeline stage to the next using a valid/ready
// handshake. It also supports a global run enable, a hazard stall and a
// flush that inserts a bubble. On a flush the control bundle is zeroed and
// the data bundle is kept. A saturating counter records how many valid
// entries were discarded by flushes.
//
// SKID = 1 : main entry plus one skid entry. ready_o depends only on
//            registered state and the start/flush/stall controls, so there
//            is no combinational path from ready_i to ready_o.
// SKID = 0 : main entry only. ready_o looks at ready_i combinationally so
//            that the stage can replace its entry in the same cycle it emits.
//
// Ports
//   clk_i       : clock, rising edge
//   rst_i       : asynchronous reset, active low
//   start_i     : run enable; low freezes all state and blocks accept/emit
//   stall_i     : hazard hold; no accept, no emit, all state held
//   flush_i     : clears both entries (control zeroed, data kept), counts drops
//   valid_i     : upstream entry valid
//   ready_o     : this stage can accept an entry this cycle
//   ctrl_i      : upstream control bundle (captured only on accept)
//   data_i      : upstream data bundle (captured only on accept)
//   valid_o     : downstream entry valid (always the main entry)
//   ready_i     : downstream can accept
//   ctrl_o      : control bundle; zero whenever the entry is empty
//   data_o      : data bundle
//   drop_cnt_o  : saturating count of valid entries discarded by flush
// ---------------------------------------------------------------------------
module pipe_stage_reg #(
    parameter int CTRL_W = 8,
    parameter int DATA_W = 64,
    parameter int SKID   = 1,
    parameter int CNT_W  = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [DATA_W-1:0] data_o,
    output logic [CNT_W-1:0]  drop_cnt_o
);

    // Saturating add of a 0..2 increment onto the drop counter. Once the
    // counter reaches all-ones it stays there until reset.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt,
                                                 input logic [1:0]       inc);
        logic [CNT_W:0] sum;
        sum = {1'b0, cnt} + (CNT_W+1)'(inc);
        if (sum[CNT_W]) begin
            return '1;
        end
        return sum[CNT_W-1:0];
    endfunction

    // Main entry (feeds the outputs)
    logic              vld_p0;
    logic [CTRL_W-1:0] ctrl_p0;
    logic [DATA_W-1:0] data_p0;
    // Skid entry (only ever written when SKID != 0)
    logic              vld_p1;
    logic [CTRL_W-1:0] ctrl_p1;
    logic [DATA_W-1:0] data_p1;
    logic [CNT_W-1:0]  drop_cnt_p0;

    logic              vld_p0_nxt;
    logic [CTRL_W-1:0] ctrl_p0_nxt;
    logic [DATA_W-1:0] data_p0_nxt;
    logic              vld_p1_nxt;
    logic [CTRL_W-1:0] ctrl_p1_nxt;
    logic [DATA_W-1:0] data_p1_nxt;
    logic [CNT_W-1:0]  drop_cnt_nxt;

    logic              run;
    logic              accept;
    logic              emit;
    logic [1:0]        drop_inc;

    // Normal operation: running, not flushing, not stalled.
    assign run = start_i & ~flush_i & ~stall_i;

    always_comb begin
        ready_o = 1'b0;
        if (SKID != 0) begin
            ready_o = run & ~vld_p1;
        end else begin
            ready_o = run & (~vld_p0 | ready_i);
        end
    end

    assign accept   = valid_i & ready_o;
    // Flush takes priority over emit, so a flushed entry is never delivered.
    assign emit     = vld_p0 & ready_i & run;
    assign drop_inc = {1'b0, vld_p0} + {1'b0, vld_p1};

    always_comb begin
        vld_p0_nxt   = vld_p0;
        ctrl_p0_nxt  = ctrl_p0;
        data_p0_nxt  = data_p0;
        vld_p1_nxt   = vld_p1;
        ctrl_p1_nxt  = ctrl_p1;
        data_p1_nxt  = data_p1;
        drop_cnt_nxt = drop_cnt_p0;

        if (start_i && flush_i) begin
            // Bubble insert: control cleared, data left as it was.
            vld_p0_nxt   = 1'b0;
            ctrl_p0_nxt  = '0;
            vld_p1_nxt   = 1'b0;
            ctrl_p1_nxt  = '0;
            drop_cnt_nxt = sat_add(drop_cnt_p0, drop_inc);
        end else if (run) begin
            if (SKID != 0) begin
                if (emit) begin
                    if (vld_p1) begin
                        // Skid full means ready_o was low, so no accept here.
                        vld_p0_nxt  = 1'b1;
                        ctrl_p0_nxt = ctrl_p1;
                        data_p0_nxt = data_p1;
                        vld_p1_nxt  = 1'b0;
                        ctrl_p1_nxt = '0;
                    end else if (accept) begin
                        vld_p0_nxt  = 1'b1;
                        ctrl_p0_nxt = ctrl_i;
                        data_p0_nxt = data_i;
                    end else begin
                        vld_p0_nxt  = 1'b0;
                        ctrl_p0_nxt = '0;
                    end
                end else if (accept) begin
                    if (!vld_p0) begin
                        vld_p0_nxt  = 1'b1;
                        ctrl_p0_nxt = ctrl_i;
                        data_p0_nxt = data_i;
                    end else begin
                        vld_p1_nxt  = 1'b1;
                        ctrl_p1_nxt = ctrl_i;
                        data_p1_nxt = data_i;
                    end
                end
            end else begin
                if (accept) begin
                    vld_p0_nxt  = 1'b1;
                    ctrl_p0_nxt = ctrl_i;
                    data_p0_nxt = data_i;
                end else if (emit) begin
                    vld_p0_nxt  = 1'b0;
                    ctrl_p0_nxt = '0;
                end
            end
        end
    end

    // ---- register stage boundary ----
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            vld_p0      <= 1'b0;
            ctrl_p0     <= '0;
            data_p0     <= '0;
            vld_p1      <= 1'b0;
            ctrl_p1     <= '0;
            data_p1     <= '0;
            drop_cnt_p0 <= '0;
        end else begin
            vld_p0      <= vld_p0_nxt;
            ctrl_p0     <= ctrl_p0_nxt;
            data_p0     <= data_p0_nxt;
            vld_p1      <= vld_p1_nxt;
            ctrl_p1     <= ctrl_p1_nxt;
            data_p1     <= data_p1_nxt;
            drop_cnt_p0 <= drop_cnt_nxt;
        end
    end

    assign valid_o    = vld_p0;
    assign ctrl_o     = ctrl_p0;
    assign data_o     = data_p0;
    assign drop_cnt_o = drop_cnt_p0;

endmodule
